// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared types and constants for the binary-to-BCD converter feeding the
// seven-segment display path.
package bin_to_bcd_converter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int BIN_WIDTH_DEF = 14;
   localparam int DIGITS_DEF    = 4;
   localparam int BCD_NIBBLE_W  = 4;

   localparam logic [BCD_NIBBLE_W-1:0] BCD_NINE    = 4'd9;
   localparam logic [BCD_NIBBLE_W-1:0] BCD_ADJ_MIN = 4'd5;
   localparam logic [BCD_NIBBLE_W-1:0] BCD_ADJ_ADD = 4'd3;

   // Largest value representable in 'digits' decimal digits (10^digits - 1).
   function automatic int max_decimal(input int digits);
      int r;
      r = 1;
      for (int i = 0; i < digits; i++) r = r * 10;
      return r - 1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Request/result bundle between a binary producer and the BCD converter.
interface bin_to_bcd_converter_if
   import bin_to_bcd_converter_pkg::*;
#(
   parameter int BIN_WIDTH = BIN_WIDTH_DEF,
   parameter int DIGITS    = DIGITS_DEF
) ();

   logic                                   start;
   logic [BIN_WIDTH-1:0]                   bin_in;
   logic                                   busy;
   logic                                   done;
   logic [DIGITS-1:0][BCD_NIBBLE_W-1:0]    bcd_out;
   logic                                   overflow;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, overflow
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, overflow
   );

endinterface

// File: rtl/bin_to_bcd_converter_digit_adjust.sv
// One double-dabble correction step for a single BCD nibble: values 5..15
// get +3 so the following left shift carries into the next digit.
module bin_to_bcd_converter_digit_adjust
   import bin_to_bcd_converter_pkg::*;
(
   input  logic [BCD_NIBBLE_W-1:0] nib_in,
   output logic [BCD_NIBBLE_W-1:0] nib_out
);

   // 4-bit add, wraps modulo 16; only reachable for nibble>=13 on invalid BCD.
   assign nib_out = (nib_in >= BCD_ADJ_MIN) ? nib_in + BCD_ADJ_ADD : nib_in;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per
// clock; result and overflow flag held until the next done pulse.
module bin_to_bcd_converter
   import bin_to_bcd_converter_pkg::*;
#(
   parameter int BIN_WIDTH = BIN_WIDTH_DEF,
   parameter int DIGITS    = DIGITS_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   bin_to_bcd_converter_if.slave bus
);

   localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
   localparam int SW    = BCD_W + BIN_WIDTH;
   localparam int CW    = $clog2(BIN_WIDTH + 1);
   localparam int MAXV  = max_decimal(DIGITS);

   localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAXV);

   state_t                              state, state_nx;
   logic [CW-1:0]                       cnt, cnt_nx;
   logic [SW-1:0]                       scr, scr_nx, scr_step;
   logic                                ovf, ovf_nx;
   logic [DIGITS-1:0][BCD_NIBBLE_W-1:0] adj;
   logic [DIGITS-1:0][BCD_NIBBLE_W-1:0] bcd_q, bcd_nx;
   logic                                ovfo_q, ovfo_nx;
   logic                                done_q, done_nx;

   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      bin_to_bcd_converter_digit_adjust u_adj (
         .nib_in  (scr[BIN_WIDTH + BCD_NIBBLE_W*d +: BCD_NIBBLE_W]),
         .nib_out (adj[d])
      );
   end

   // Adjust every BCD nibble, then shift the whole scratch word left by one.
   assign scr_step = {adj, scr[BIN_WIDTH-1:0]} << 1;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      scr_nx   = scr;
      ovf_nx   = ovf;
      bcd_nx   = bcd_q;
      ovfo_nx  = ovfo_q;
      done_nx  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_nx = ST_SHIFT;
               cnt_nx   = CW'(BIN_WIDTH);
               scr_nx   = {{BCD_W{1'b0}}, bus.bin_in};
               ovf_nx   = bus.bin_in > MAX_BIN;
            end
         end
         ST_SHIFT: begin
            scr_nx = scr_step;
            cnt_nx = cnt - 1'b1;
            // Final shift: publish straight from the shifted word so done
            // lands in the cycle right after busy drops.
            if (cnt == CW'(1)) begin
               state_nx = ST_IDLE;
               done_nx  = 1'b1;
               ovfo_nx  = ovf;
               bcd_nx   = ovf ? {DIGITS{BCD_NINE}} : scr_step[SW-1 -: BCD_W];
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         scr    <= '0;
         ovf    <= 1'b0;
         bcd_q  <= '0;
         ovfo_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         scr    <= scr_nx;
         ovf    <= ovf_nx;
         bcd_q  <= bcd_nx;
         ovfo_q <= ovfo_nx;
         done_q <= done_nx;
      end
   end

   assign bus.busy     = (state == ST_SHIFT);
   assign bus.done     = done_q;
   assign bus.bcd_out  = bcd_q;
   assign bus.overflow = ovfo_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed and strided-sweep check of the binary-to-BCD converter: latency,
// handshake, overflow saturation, start filtering and async reset abort.
module tb_bin_to_bcd_converter;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   bin_to_bcd_converter_if #(.BIN_WIDTH(14), .DIGITS(4)) bus ();

   bin_to_bcd_converter #(.BIN_WIDTH(14), .DIGITS(4)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Decimal digit extraction by division, saturating to 9999.
   function automatic logic [15:0] ref_bcd(input int v);
      if (v > 9999) return 16'h9999;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // One conversion from an idle DUT; optionally pulses start twice mid-run.
   task automatic run(input logic [13:0] v, input logic [15:0] ebcd, input logic eovf,
                      input string tag, input bit pulses);
      int          edges;
      int          busyc;
      bit          moved;
      logic [15:0] prev;
      bus.bin_in = v;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.bin_in = ~v;
      prev  = bus.bcd_out;
      edges = 0;
      busyc = 0;
      moved = 1'b0;
      while (!bus.done && edges < 40) begin
         if (bus.busy) busyc++;
         if (bus.bcd_out !== prev || bus.overflow !== dut.ovfo_q) moved = 1'b1;
         bus.start = pulses && (edges == 2 || edges == 9);
         @(posedge clk); #1;
         edges++;
      end
      bus.start = 1'b0;
      chk({tag, "_latency"}, edges, 14);
      chk({tag, "_busy_cycles"}, busyc, 14);
      chk({tag, "_busy_at_done"}, bus.busy, 0);
      chk({tag, "_stable"}, moved, 0);
      chk({tag, "_bcd"}, bus.bcd_out, ebcd);
      chk({tag, "_ovf"}, bus.overflow, eovf);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, bus.done, 0);
      chk({tag, "_idle_after"}, bus.busy, 0);
   endtask

   initial begin
      int edges;
      n_chk      = 0;
      n_fail     = 0;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.bin_in = '0;
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_bcd", bus.bcd_out, 0);
      chk("rst_ovf", bus.overflow, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      run(14'd0,     16'h0000, 1'b0, "zero",  1'b0);
      run(14'd1234,  16'h1234, 1'b0, "v1234", 1'b0);
      run(14'd9999,  16'h9999, 1'b0, "v9999", 1'b0);
      run(14'd12000, 16'h9999, 1'b1, "v12000", 1'b0);
      run(14'd42,    16'h0042, 1'b0, "ign_start", 1'b1);

      // start held high: 7 then 8 back-to-back, one result per 15 cycles
      bus.bin_in = 14'd7;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.bin_in = 14'd8;
      edges = 0;
      while (!bus.done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      chk("b2b_lat1", edges, 14);
      chk("b2b_bcd1", bus.bcd_out, 16'h0007);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("b2b_reaccept", bus.busy, 1);
      chk("b2b_hold", bus.bcd_out, 16'h0007);
      edges = 0;
      while (!bus.done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (!bus.done && bus.bcd_out !== 16'h0007) chk("b2b_midrun", bus.bcd_out, 16'h0007);
      end
      chk("b2b_lat2", edges, 14);
      chk("b2b_bcd2", bus.bcd_out, 16'h0008);
      @(posedge clk); #1;

      // async reset in the middle of a 5678 conversion
      bus.bin_in = 14'd5678;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done, 0);
      chk("arst_bcd", bus.bcd_out, 0);
      chk("arst_ovf", bus.overflow, 0);
      repeat (12) @(posedge clk);
      #1;
      chk("arst_nodone", bus.done, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run(14'd5678,  16'h5678, 1'b0, "after_rst", 1'b0);

      run(14'd9998,  16'h9998, 1'b0, "v9998",  1'b0);
      run(14'd10000, 16'h9999, 1'b1, "v10000", 1'b0);
      run(14'd16383, 16'h9999, 1'b1, "v16383", 1'b0);
      run(14'd5,     16'h0005, 1'b0, "v5",     1'b0);
      run(14'd909,   16'h0909, 1'b0, "v909",   1'b0);

      for (int v = 0; v < 16384; v += 7)
         run(14'(v), ref_bcd(v), v > 9999, "sweep", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
